ammo_loader: RTL and testbench
==============================

AMMO_LOADER -- requirements
Module: ammo_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N, 9, ammo word width.
- SW, 12, magazine stock width.
- MAX_AMMO, 300, weapon capacity in rounds.
- LOAD_CYCLES, 4, cycles for which loading stays high per transfer (at least 1).
- COOL_CYCLES, 2, lockout cycles after a transfer (at least 1).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is rising-edge.
- rst, in, 1, synchronous, active-high reset.
- reload_req, in, 1, single-cycle reload request.
- ammo_level, in, N, current round count fed back from the weapon counter output.
- stock_add, in, 1, restock strobe.
- stock_in, in, SW, rounds added on stock_add.
- ammo_out, out, N, load value presented to the weapon's ammo input.
- loading, out, 1, drives the weapon's loadingAmmo input.
- busy, out, 1, high in any state other than IDLE.
- stock, out, SW, rounds remaining in the magazine.
- error, out, 1, one-cycle pulse when a reload is refused for lack of stock.
REQ-003 There is one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 The block SHALL implement four states: IDLE, CALC, LOAD, COOL.
REQ-005 IDLE, with reload_req=1:
- If ammo_level>=MAX_AMMO: stay in IDLE, no error (no-op).
- Else if stock==0: stay in IDLE and pulse error=1 for the following cycle.
- Otherwise: go to CALC.
REQ-006 CALC SHALL last exactly 1 cycle and register:
- need = MAX_AMMO - ammo_level, sampled during the CALC cycle.
- amt = min(need, stock).
- target = ammo_level + amt, held in ammo_out.
- Then go to LOAD.
REQ-007 On entry to LOAD, stock SHALL decrease by amt in the same edge that asserts loading.
REQ-008 LOAD: loading=1 for exactly LOAD_CYCLES consecutive cycles with ammo_out stable at target, then go to COOL.
REQ-009 COOL: loading=0 for exactly COOL_CYCLES cycles, then return to IDLE.
REQ-010 reload_req received in CALC, LOAD or COOL SHALL be dropped: not queued, no error.
REQ-011 Total request-to-idle latency SHALL be 1+LOAD_CYCLES+COOL_CYCLES cycles after the accepting edge; loading rises 2 edges after reload_req is sampled.
REQ-012 Restock (stock_add=1) SHALL be accepted in every state.
- stock adds stock_in, saturating at 2^SW-1.
- If it coincides with the LOAD-entry decrement, the result is stock - amt + stock_in, saturated.
REQ-013 Arithmetic SHALL be unsigned with no wrap-around.
- stock never goes below 0 (guaranteed since amt<=stock).
- ammo_out never exceeds MAX_AMMO.
REQ-014 ammo_out SHALL hold its last target while outside LOAD; the weapon ignores it while loading=0.
REQ-015 busy SHALL equal (state != IDLE); error SHALL never coincide with busy=1.

Reset
REQ-016 When rst=1 at an edge, the block SHALL go to IDLE with the following values:
- loading=0, busy=0, error=0.
- ammo_out=0, stock=0.
- All cycle counters cleared.
REQ-017 Reset SHALL take priority over reload_req and stock_add in the same cycle.
REQ-018 Reset during LOAD SHALL drop loading on that edge with no further stock change; the transfer already deducted is not refunded.

Verification
REQ-019 Scenario: restock.
- Stimulus: after reset, stock_add=1, stock_in=500 for 1 cycle.
- Response: stock=500, busy=0, loading=0.
REQ-020 Scenario: normal reload.
- Stimulus: stock=500, ammo_level=100, reload_req pulse.
- Response: ammo_out=300; loading high for 4 cycles starting 2 edges after the request; stock=300; busy clears after 7 cycles.
REQ-021 Scenario: partial reload limited by stock.
- Stimulus: stock=50, ammo_level=10, reload_req.
- Response: ammo_out=60, stock=0.
- A second reload_req after return to IDLE: error pulses for 1 cycle and loading stays 0.
REQ-022 Scenario: full or busy requests.
- Stimulus: ammo_level=300 with reload_req.
- Response: no state change, no error.
- Stimulus: reload_req repeated during LOAD.
- Response: ignored; exactly one transfer occurs.
REQ-023 Scenario: simultaneous restock and saturation.
- Stimulus: stock_add with stock_in=100 on the LOAD-entry edge (stock=80, amt=80).
- Response: stock=100.
- Stimulus: stock=4000 with stock_in=200.
- Response: stock=4095.
REQ-024 Scenario: reset mid-LOAD.
- Stimulus: rst asserted in the 2nd LOAD cycle.
- Response: next cycle loading=0, busy=0, stock=0, ammo_out=0.

Source files
------------

// File: rtl/ammo_loader_if.sv
// Reload/restock bus between the ammo loader and its controller/weapon side.
// master drives requests and restock, slave (the loader) drives load outputs.
interface ammo_loader_if #(
    parameter int N  = 9,
    parameter int SW = 12
);
    logic          reload_req;
    logic [N-1:0]  ammo_level;
    logic          stock_add;
    logic [SW-1:0] stock_in;
    logic [N-1:0]  ammo_out;
    logic          loading;
    logic          busy;
    logic [SW-1:0] stock;
    logic          error;

    modport master (
        output reload_req, ammo_level, stock_add, stock_in,
        input  ammo_out, loading, busy, stock, error
    );

    modport slave (
        input  reload_req, ammo_level, stock_add, stock_in,
        output ammo_out, loading, busy, stock, error
    );
endinterface

// File: rtl/ammo_loader.sv
// Magazine-to-weapon reloader: IDLE -> CALC (1) -> LOAD (LOAD_CYCLES) -> COOL (COOL_CYCLES) -> IDLE.
// No backpressure: reload requests while busy are dropped; restock is accepted every cycle.
module ammo_loader #(
    parameter int N           = 9,
    parameter int SW          = 12,
    parameter int MAX_AMMO    = 300,
    parameter int LOAD_CYCLES = 4,
    parameter int COOL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    ammo_loader_if.slave bus
);
    localparam int AW   = ((N > SW) ? N : SW) + 1;
    localparam int SW1  = SW + 1;
    localparam int CMAX = (LOAD_CYCLES > COOL_CYCLES) ? LOAD_CYCLES : COOL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW-1:0] MAX_W = AW'(MAX_AMMO);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_LOAD = 2'd2,
        S_COOL = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_error;
    logic          w_error_nxt;
    logic          w_load_entry;
    logic [N-1:0]  r_ammo_out;
    logic [SW-1:0] r_stock;

    logic [AW-1:0]  w_level;
    logic [AW-1:0]  w_stock_x;
    logic [AW-1:0]  w_need;
    logic [AW-1:0]  w_amt;
    logic [AW-1:0]  w_target;
    logic           w_full;
    logic [SW1-1:0] w_stock_sum;
    logic [SW-1:0]  w_stock_nxt;

    // Transfer size is evaluated combinationally during CALC and committed on the LOAD-entry edge.
    assign w_level   = AW'(bus.ammo_level);
    assign w_stock_x = AW'(r_stock);
    assign w_full    = (w_level >= MAX_W);
    assign w_need    = w_full ? '0 : (MAX_W - w_level);
    assign w_amt     = (w_need < w_stock_x) ? w_need : w_stock_x;
    assign w_target  = w_full ? MAX_W : (w_level + w_amt);

    // amt never exceeds stock, so only the restock side can overflow.
    assign w_stock_sum = {1'b0, r_stock}
                       - (w_load_entry  ? SW1'(w_amt)          : '0)
                       + (bus.stock_add ? {1'b0, bus.stock_in} : '0);
    assign w_stock_nxt = w_stock_sum[SW] ? '1 : w_stock_sum[SW-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_error_nxt  = 1'b0;
        w_load_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.reload_req && !w_full) begin
                    if (r_stock == '0) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_state_nxt  = S_LOAD;
                w_cnt_nxt    = '0;
                w_load_entry = 1'b1;
            end
            S_LOAD: begin
                if (r_cnt == CW'(LOAD_CYCLES - 1)) begin
                    w_state_nxt = S_COOL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_COOL: begin
                if (r_cnt == CW'(COOL_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_error    <= 1'b0;
            r_ammo_out <= '0;
            r_stock    <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_error <= w_error_nxt;
            r_stock <= w_stock_nxt;
            if (w_load_entry) begin
                r_ammo_out <= N'(w_target);
            end
        end
    end

    assign bus.ammo_out = r_ammo_out;
    assign bus.loading  = (r_state == S_LOAD);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.stock    = r_stock;
    assign bus.error    = r_error;
endmodule

// File: tb/tb_ammo_loader.sv
// Directed bench for ammo_loader: transfers are scored against a queue of expected results.
module tb_ammo_loader;
    localparam int N   = 9;
    localparam int SW  = 12;
    localparam int MAX = 300;
    localparam int LC  = 4;
    localparam int CC  = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ammo_loader_if #(.N(N), .SW(SW)) bus ();

    ammo_loader #(
        .N(N), .SW(SW), .MAX_AMMO(MAX), .LOAD_CYCLES(LC), .COOL_CYCLES(CC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int ammo;
        int stock;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_stock     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic restock(input int amt);
        bus.stock_add = 1'b1;
        bus.stock_in  = SW'(amt);
        tick();
        bus.stock_add = 1'b0;
        m_stock = sat(m_stock + amt);
    endtask

    // Full reload transaction; spam re-asserts reload_req throughout LOAD, addin restocks on the LOAD-entry edge.
    task automatic reload(input int lvl, input bit spam, input int addin);
        int   need, amt, first, nload, lat;
        exp_t e, got;
        need    = MAX - lvl;
        amt     = (need < m_stock) ? need : m_stock;
        e.ammo  = lvl + amt;
        m_stock = sat(m_stock - amt + addin);
        e.stock = m_stock;
        sb.push_back(e);
        first = 0; nload = 0; lat = 0;
        bus.ammo_level = N'(lvl);
        bus.reload_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            bus.reload_req = spam && bus.loading;
            if (i == 1) begin
                chk("calc_busy", bus.busy, 1);
                chk("calc_loading", bus.loading, 0);
                if (addin != 0) begin
                    bus.stock_add = 1'b1;
                    bus.stock_in  = SW'(addin);
                end
            end else begin
                bus.stock_add = 1'b0;
            end
            if (bus.loading) begin
                nload++;
                if (first == 0) begin
                    first = i;
                    chk("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        got = sb.pop_front();
                        chk("ammo_out", bus.ammo_out, got.ammo);
                        chk("stock_after_load", bus.stock, got.stock);
                    end
                end
            end
            if (!bus.busy) begin
                lat = i;
                break;
            end
        end
        bus.reload_req = 1'b0;
        chk("load_edge", first, 2);
        chk("load_len", nload, LC);
        chk("latency", lat, 2 + LC + CC);
    endtask

    initial begin
        rst = 1'b1;
        bus.reload_req = 1'b0;
        bus.ammo_level = '0;
        bus.stock_add  = 1'b0;
        bus.stock_in   = '0;
        tick();
        tick();
        chk("rst_loading", bus.loading, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_ammo_out", bus.ammo_out, 0);
        chk("rst_stock", bus.stock, 0);
        rst = 1'b0;

        restock(500);
        chk("restock_stock", bus.stock, 500);
        chk("restock_busy", bus.busy, 0);
        chk("restock_loading", bus.loading, 0);

        reload(100, 1'b0, 0);

        // Already full: request is a no-op.
        bus.ammo_level = N'(300);
        bus.reload_req = 1'b1;
        tick();
        bus.reload_req = 1'b0;
        chk("full_busy", bus.busy, 0);
        chk("full_error", bus.error, 0);
        tick();
        chk("full_error2", bus.error, 0);
        chk("full_stock", bus.stock, m_stock);
        chk("hold_ammo_out", bus.ammo_out, 300);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_stock = 0;
        chk("rst2_stock", bus.stock, 0);

        restock(50);
        reload(10, 1'b1, 0);
        chk("partial_stock", bus.stock, 0);

        // Empty magazine: one-cycle error, no transfer.
        bus.ammo_level = N'(60);
        bus.reload_req = 1'b1;
        tick();
        bus.reload_req = 1'b0;
        chk("empty_error", bus.error, 1);
        chk("empty_busy", bus.busy, 0);
        tick();
        chk("empty_error_end", bus.error, 0);
        chk("empty_loading", bus.loading, 0);
        chk("empty_busy2", bus.busy, 0);

        restock(80);
        reload(0, 1'b0, 100);

        restock(3900);
        chk("stock_4000", bus.stock, 4000);
        restock(200);
        chk("stock_sat", bus.stock, SMAX);

        // Reset during the second LOAD cycle; restock and request in the same cycle lose to reset.
        bus.ammo_level = N'(200);
        bus.reload_req = 1'b1;
        tick();
        bus.reload_req = 1'b0;
        tick();
        chk("mid_load1", bus.loading, 1);
        tick();
        chk("mid_load2", bus.loading, 1);
        chk("mid_stock", bus.stock, SMAX - 100);
        rst = 1'b1;
        bus.stock_add  = 1'b1;
        bus.stock_in   = SW'(7);
        bus.reload_req = 1'b1;
        tick();
        rst = 1'b0;
        bus.stock_add  = 1'b0;
        bus.reload_req = 1'b0;
        chk("rst_mid_loading", bus.loading, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_stock", bus.stock, 0);
        chk("rst_mid_ammo_out", bus.ammo_out, 0);
        chk("rst_mid_error", bus.error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
